// File: rtl/regfile_mp.sv
// Multi-port register file with write priority, optional bypass,
// busy scoreboard and a post-reset init sequence gated by ready.
module regfile_mp #(
  parameter int W        = 16,
  parameter int DEPTH    = 16,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ONES_IDX = 13,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W-1:0]         pc,
  input  logic [1:0]           wr_en,
  input  logic [2*AW-1:0]      wr_addr,
  input  logic [2*W-1:0]       wr_data,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*W-1:0]  rd_data,
  input  logic                 busy_set_en,
  input  logic [AW-1:0]        busy_set_addr,
  output logic [DEPTH-1:0]     busy,
  output logic                 ready
);

  localparam logic [AW-1:0] PC_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 2);
  localparam logic [AW-1:0] ONES   = AW'(ONES_IDX);

  typedef enum logic {INIT, RUN} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_init_idx;
  logic             r_ready;
  logic [DEPTH-1:0] r_busy;
  logic [W-1:0]     r_regs [DEPTH-1];

  logic [AW-1:0]    w_wa [2];
  logic [W-1:0]     w_wd [2];
  logic [1:0]       w_wv;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [W-1:0]     w_pc_word;
  logic             w_unused_pc;

  assign w_wa[0] = wr_addr[0 +: AW];
  assign w_wa[1] = wr_addr[AW +: AW];
  assign w_wd[0] = wr_data[0 +: W];
  assign w_wd[1] = wr_data[W +: W];

  // A write only lands when running and not aimed at the PC slot
  assign w_wv[0] = r_ready && wr_en[0] && (w_wa[0] != PC_IDX);
  assign w_wv[1] = r_ready && wr_en[1] && (w_wa[1] != PC_IDX);

  assign w_pc_word   = {2'b00, pc[W-1:2]};
  assign w_unused_pc = ^pc[1:0];

  // Next scoreboard: writes clear, a new producer sets (set wins)
  always_comb begin
    w_busy_nxt = r_busy;
    for (int p = 0; p < 2; p++) begin
      if (wr_en[p]) w_busy_nxt[w_wa[p]] = 1'b0;
    end
    if (busy_set_en) w_busy_nxt[busy_set_addr] = 1'b1;
    w_busy_nxt[PC_IDX] = 1'b0;
  end

  // Init/run sequencer, ready flag and busy scoreboard
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= INIT;
      r_init_idx <= '0;
      r_ready    <= 1'b0;
      r_busy     <= '0;
    end else begin
      unique case (r_state)
        INIT: begin
          r_init_idx <= r_init_idx + 1'b1;
          if (r_init_idx == LAST) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: r_busy <= w_busy_nxt;
        default: r_state <= INIT;
      endcase
    end
  end

  // Storage: init pattern during INIT, port 0 then port 1 in RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == INIT) begin
        r_regs[r_init_idx] <= (r_init_idx == ONES) ? '1 : '0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (w_wv[p]) r_regs[w_wa[p]] <= w_wd[p];
        end
      end
    end
  end

  // Combinational read ports with optional write bypass
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic [AW-1:0] w_idx;
    logic [W-1:0]  w_val;

    assign w_ra  = rd_addr[r*AW +: AW];
    assign w_idx = (w_ra == PC_IDX) ? '0 : w_ra;

    always_comb begin
      w_val = r_regs[w_idx];
      if (w_ra == PC_IDX) w_val = w_pc_word;
      if (BYPASS != 0) begin
        for (int p = 0; p < 2; p++) begin
          if (w_wv[p] && (w_wa[p] == w_ra)) w_val = w_wd[p];
        end
      end
      if (!r_ready) w_val = '0;
    end

    assign rd_data[r*W +: W] = w_val;
  end

  assign busy  = r_busy;
  assign ready = r_ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed table-driven bench for regfile_mp (BYPASS=1 and BYPASS=0)
// plus hand sequences for init timing and reset recovery.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] rd_data_nb;
  logic        busy_set_en;
  logic [3:0]  busy_set_addr;
  logic [15:0] busy;
  logic [15:0] busy_nb;
  logic        ready;
  logic        ready_nb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
    .busy(busy), .ready(ready)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .pc(pc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
    .busy(busy_nb), .ready(ready_nb)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0;
    busy_set_en = 1'b0; busy_set_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles from reset release until ready; checks idle outputs
  task automatic wait_ready(input string name, input bit drive_junk);
    int n = 0;
    bit bad = 0;
    while (!ready && n < 20) begin
      if (drive_junk) begin
        wr_en = 2'b11; wr_addr = {4'd4, 4'd4};
        wr_data = 32'h1234_5678;
        busy_set_en = 1'b1; busy_set_addr = 4'd4;
        rd_addr = {4'd4, 4'd4};
        #1;
        if (rd_data !== 32'h0 || busy !== 16'h0) bad = 1;
      end
      tick();
      n++;
    end
    idle();
    chk({name, "_cycles"}, n, 15);
    chk({name, "_ready_nb"}, {31'b0, ready_nb}, 1);
    if (drive_junk) chk({name, "_quiet"}, {31'b0, bad}, 0);
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [3:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    logic        bse;
    logic [3:0]  bsa;
    logic [3:0]  ra0, ra1;
    logic [15:0] pcv;
    logic [15:0] e0, e1, enb0, ebusy;
  } vec_t;

  vec_t v [13];

  initial begin
    v[0]  = '{2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0,
              4'd0, 4'd13, 16'h0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    v[1]  = '{2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0,
              4'd14, 4'd12, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    v[2]  = '{2'b01, 4'd3, 4'd0, 16'h1234, 16'h0, 1'b0, 4'd0,
              4'd3, 4'd3, 16'h0, 16'h1234, 16'h1234, 16'h0000, 16'h0000};
    v[3]  = '{2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0,
              4'd3, 4'd0, 16'h0, 16'h1234, 16'h0000, 16'h1234, 16'h0000};
    v[4]  = '{2'b11, 4'd5, 4'd5, 16'hAAAA, 16'h5555, 1'b0, 4'd0,
              4'd5, 4'd4, 16'h0, 16'h5555, 16'h0000, 16'h0000, 16'h0000};
    v[5]  = '{2'b01, 4'd15, 4'd0, 16'hDEAD, 16'h0, 1'b0, 4'd0,
              4'd15, 4'd5, 16'h0104, 16'h0041, 16'h5555, 16'h0041, 16'h0000};
    v[6]  = '{2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0,
              4'd15, 4'd15, 16'h0104, 16'h0041, 16'h0041, 16'h0041, 16'h0000};
    v[7]  = '{2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1, 4'd7,
              4'd7, 4'd13, 16'h0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080};
    v[8]  = '{2'b10, 4'd0, 4'd7, 16'h0, 16'h7777, 1'b1, 4'd7,
              4'd7, 4'd7, 16'h0, 16'h7777, 16'h7777, 16'h0000, 16'h0080};
    v[9]  = '{2'b01, 4'd7, 4'd0, 16'h0102, 16'h0, 1'b0, 4'd0,
              4'd7, 4'd1, 16'h0, 16'h0102, 16'h0000, 16'h7777, 16'h0000};
    v[10] = '{2'b01, 4'd4, 4'd0, 16'hBEEF, 16'h0, 1'b1, 4'd15,
              4'd4, 4'd13, 16'h0, 16'hBEEF, 16'hFFFF, 16'h0000, 16'h0000};
    v[11] = '{2'b11, 4'd2, 4'd2, 16'h1111, 16'h2222, 1'b1, 4'd4,
              4'd2, 4'd4, 16'h0, 16'h2222, 16'hBEEF, 16'h0000, 16'h0010};
    v[12] = '{2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1, 4'd9,
              4'd2, 4'd15, 16'hFFFF, 16'h2222, 16'h3FFF, 16'h2222, 16'h0210};

    reset = 1'b1; pc = '0; rd_addr = '0;
    idle();
    tick();
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_busy", {16'b0, busy}, 0);
    chk("rst_rd", rd_data, 0);

    reset = 1'b0;
    wait_ready("init", 1'b0);

    for (int i = 0; i < 13; i++) begin
      wr_en = v[i].we;
      wr_addr = {v[i].wa1, v[i].wa0};
      wr_data = {v[i].wd1, v[i].wd0};
      busy_set_en = v[i].bse;
      busy_set_addr = v[i].bsa;
      rd_addr = {v[i].ra1, v[i].ra0};
      pc = v[i].pcv;
      #1;
      chk($sformatf("v%0d_rd0", i), {16'b0, rd_data[15:0]}, {16'b0, v[i].e0});
      chk($sformatf("v%0d_rd1", i), {16'b0, rd_data[31:16]}, {16'b0, v[i].e1});
      chk($sformatf("v%0d_nb0", i), {16'b0, rd_data_nb[15:0]},
          {16'b0, v[i].enb0});
      tick();
      chk($sformatf("v%0d_busy", i), {16'b0, busy}, {16'b0, v[i].ebusy});
    end

    idle(); pc = '0;

    // Reset mid-RUN: r4 holds BEEF with busy[4] set
    rd_addr = {4'd13, 4'd4};
    #1;
    chk("pre_rst_r4", {16'b0, rd_data[15:0]}, 32'h0000_BEEF);
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", {31'b0, ready}, 0);
    chk("mid_rst_busy", {16'b0, busy}, 0);
    chk("mid_rst_rd", rd_data, 0);
    reset = 1'b0;
    wait_ready("rerun", 1'b1);
    rd_addr = {4'd13, 4'd4};
    #1;
    chk("post_r4", {16'b0, rd_data[15:0]}, 0);
    chk("post_r13", {16'b0, rd_data[31:16]}, 32'h0000_FFFF);
    chk("post_busy", {16'b0, busy}, 0);

    // Reset mid-INIT restarts the sequence from index 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("midinit_ready", {31'b0, ready}, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("reinit", 1'b0);
    rd_addr = {4'd14, 4'd13};
    #1;
    chk("reinit_rd", rd_data, 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
